// File: rtl/inv_cipher_iter_pkg.sv
// Shared cipher package: AES state type, inverse S-box and the inverse
// round primitives (InvShiftRows, InvSubBytes, InvMixColumns, AddRoundKey).
// State byte i sits at bits [127-8*i -: 8]; byte i is row i%4 of column i/4.
package inv_cipher_iter_pkg;

  localparam int AES128_NR = 10;

  typedef logic [127:0] t_opaque_AESState;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic t_opaque_AESState inv_sub_bytes(input t_opaque_AESState s);
    t_opaque_AESState r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  // Row r rotates right by r columns: out[c][r] = s[(c - r) mod 4][r].
  function automatic t_opaque_AESState inv_shift_rows(input t_opaque_AESState s);
    t_opaque_AESState r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

  // Circulant {0e,0b,0d,09} built from x2/x4/x8 xtime chains:
  // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
  function automatic t_opaque_AESState inv_mix_columns(input t_opaque_AESState s);
    t_opaque_AESState r;
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        a[k]  = s[127-8*(4*c+k) -: 8];
        x2[k] = xtime(a[k]);
        x4[k] = xtime(x2[k]);
        x8[k] = xtime(x4[k]);
      end
      for (int k = 0; k < 4; k++) begin
        r[127-8*(4*c+k) -: 8] = (x8[k] ^ x4[k] ^ x2[k])
                              ^ (x8[(k+1)%4] ^ x2[(k+1)%4] ^ a[(k+1)%4])
                              ^ (x8[(k+2)%4] ^ x4[(k+2)%4] ^ a[(k+2)%4])
                              ^ (x8[(k+3)%4] ^ a[(k+3)%4]);
      end
    end
    return r;
  endfunction

  function automatic t_opaque_AESState add_round_key(input t_opaque_AESState s,
                                                     input t_opaque_AESState k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/inv_cipher_iter_if.sv
// Handshake bundle for inv_cipher_iter.
//   in_valid/in_ready/in_data    : ciphertext stream into the block
//   out_valid/out_ready/out_data : plaintext stream out of the block
//   key_idx/round_key            : combinational read port of the round-key store
// slave = the cipher block, master = the surrounding environment.
interface inv_cipher_iter_if #(
  parameter int KEY_IDX_W = 4
);
  import inv_cipher_iter_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  t_opaque_AESState     in_data;
  logic                 out_valid;
  logic                 out_ready;
  t_opaque_AESState     out_data;
  logic [KEY_IDX_W-1:0] key_idx;
  t_opaque_AESState     round_key;

  modport slave (
    input  in_valid, in_data, out_ready, round_key,
    output in_ready, out_valid, out_data, key_idx
  );

  modport master (
    output in_valid, in_data, out_ready, round_key,
    input  in_ready, out_valid, out_data, key_idx
  );

endinterface

// File: rtl/inv_cipher_iter_inv_round.sv
// One combinational AES inverse round:
//   next_state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key),
//   with InvMixColumns bypassed when is_last.
// Ports: state, round_key, is_last in; next_state out.
module inv_round
  import inv_cipher_iter_pkg::*;
(
  input  t_opaque_AESState state,
  input  t_opaque_AESState round_key,
  input  logic             is_last,
  output t_opaque_AESState next_state
);

  t_opaque_AESState t;

  always_comb begin
    t          = add_round_key(inv_sub_bytes(inv_shift_rows(state)), round_key);
    next_state = is_last ? t : inv_mix_columns(t);
  end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, one block in flight.
// Round keys are read from an external store through key_idx/round_key.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - inv_cipher_iter_if.slave: ciphertext in, plaintext out, key port
module inv_cipher_iter
  import inv_cipher_iter_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int KEY_IDX_W = 4
) (
  input logic               clk,
  input logic               rst,
  inv_cipher_iter_if.slave  bus
);

  if (NR != AES128_NR) begin : g_nr_chk
    $error("inv_cipher_iter: NR must be %0d", AES128_NR);
  end
  if ((1 << KEY_IDX_W) <= NR) begin : g_kw_chk
    $error("inv_cipher_iter: KEY_IDX_W too narrow for NR");
  end

  fsm_e                 fsm;
  logic [KEY_IDX_W-1:0] rnd;
  t_opaque_AESState     state_p0;
  t_opaque_AESState     next_p0;
  logic                 rdy_p0;
  logic                 vld_p0;

  inv_round u_inv_round (
    .state      (state_p0),
    .round_key  (bus.round_key),
    .is_last    (rnd == '0),
    .next_state (next_p0)
  );

  // Round-key index: the counter while iterating, the initial-whitening key otherwise.
  assign bus.key_idx  = (fsm == ST_RUN) ? rnd : KEY_IDX_W'(NR);
  assign bus.in_ready = rdy_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_data = vld_p0 ? state_p0 : '0;

  // Stage p0: state register, round counter, handshake flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm      <= ST_IDLE;
      state_p0 <= '0;
      rnd      <= '0;
      rdy_p0   <= 1'b1;
      vld_p0   <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_p0 <= add_round_key(bus.in_data, bus.round_key);
            rnd      <= KEY_IDX_W'(NR - 1);
            rdy_p0   <= 1'b0;
            fsm      <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_p0 <= next_p0;
          if (rnd == '0) begin
            vld_p0 <= 1'b1;
            fsm    <= ST_DONE;
          end else begin
            rnd <= rnd - KEY_IDX_W'(1);
          end
        end
        ST_DONE: begin
          // in_valid is deliberately not looked at here: no in/out overlap.
          if (bus.out_ready) begin
            vld_p0 <= 1'b0;
            rdy_p0 <= 1'b1;
            fsm    <= ST_IDLE;
          end
        end
        default: begin
          vld_p0 <= 1'b0;
          rdy_p0 <= 1'b1;
          fsm    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: directed sequence with a forward-AES reference
// model (S-box derived from GF(2^8) inverses, generic GF multiply) and a
// round-key store that answers key_idx combinationally.
module tb_inv_cipher_iter;
  import inv_cipher_iter_pkg::*;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  inv_cipher_iter_if #(.KEY_IDX_W(4)) bus ();

  inv_cipher_iter #(.NR(10), .KEY_IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [127:0] rk [11];
  assign bus.round_key = (bus.key_idx <= 4'd10) ? rk[bus.key_idx] : '0;

  logic [127:0] ur_state;
  logic [127:0] ur_key;
  logic         ur_last;
  logic [127:0] ur_out;

  inv_round u_unit (
    .state      (ur_state),
    .round_key  (ur_key),
    .is_last    (ur_last),
    .next_state (ur_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   sbox  [256];
  logic [127:0] sched [11];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int k = 0; k < 4; k++)
        r[127-8*(4*c+k) -: 8] = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k+1)%4])
                              ^ a[(k+2)%4] ^ a[(k+3)%4];
    end
    return r;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ sched[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r != 10) s = mix_columns(s);
      s = s ^ sched[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_keys_from_sched();
    for (int r = 0; r < 11; r++) rk[r] = sched[r];
  endtask

  logic [127:0] ks  [3][11];
  logic [127:0] pts [3];
  logic [127:0] cts [3];
  int           acc_t [3];

  initial begin
    int  cyc;
    int  nacc;
    int  nout;
    bit  seen;
    logic [127:0] x;
    logic [127:0] k;

    passed = 0;
    total  = 0;
    build_sbox();

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < 11; r++) rk[r] = '0;
    tick();
    tick();

    check("rst_in_ready",  128'(bus.in_ready),  128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data",  bus.out_data,        128'd0);
    check("rst_key_idx",   128'(bus.key_idx),   128'd10);
    rst = 1'b1;
    tick();

    // FIPS-197 C.1 with key_idx trace and output backpressure
    expand(KEY_C1);
    load_keys_from_sched();
    bus.in_data  = CT_C1;
    bus.in_valid = 1'b1;
    check("idle_key_idx",  128'(bus.key_idx),  128'd10);
    check("idle_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int r = 9; r >= 0; r--) begin
      check($sformatf("run_key_idx_%0d", r), 128'(bus.key_idx), 128'(r));
      check("run_in_ready",  128'(bus.in_ready),  128'd0);
      check("run_out_valid", 128'(bus.out_valid), 128'd0);
      tick();
    end
    check("c1_out_valid", 128'(bus.out_valid), 128'd1);
    check("c1_out_data",  bus.out_data,        PT_C1);
    check("done_key_idx", 128'(bus.key_idx),   128'd10);
    check("done_in_ready", 128'(bus.in_ready), 128'd0);

    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = rand128();
      tick();
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_out_data",  bus.out_data,        PT_C1);
      check("bp_in_ready",  128'(bus.in_ready),  128'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    check("hs_in_ready",  128'(bus.in_ready),  128'd1);
    check("hs_out_valid", 128'(bus.out_valid), 128'd0);
    check("hs_key_idx",   128'(bus.key_idx),   128'd10);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check("hs_no_accept", 128'(bus.in_ready), 128'd1);

    // Reset in the middle of RUN at rnd=4
    bus.in_data  = CT_C1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("mid_key_idx", 128'(bus.key_idx), 128'd4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_out_valid", 128'(bus.out_valid), 128'd0);
    check("mid_in_ready",  128'(bus.in_ready),  128'd1);
    check("mid_key_idx10", 128'(bus.key_idx),   128'd10);
    check("mid_out_data",  bus.out_data,        128'd0);
    seen = 1'b0;
    repeat (13) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("mid_discarded", 128'(seen), 128'd0);

    bus.in_data   = CT_C1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    check("rerun_out_valid", 128'(bus.out_valid), 128'd1);
    check("rerun_latency",   128'(cyc),           128'd11);
    check("rerun_out_data",  bus.out_data,        PT_C1);
    tick();

    // Back-to-back random blocks, in_valid and out_ready held high
    for (int n = 0; n < 3; n++) begin
      expand(rand128());
      pts[n] = rand128();
      cts[n] = encrypt(pts[n]);
      for (int r = 0; r < 11; r++) ks[n][r] = sched[r];
    end
    for (int r = 0; r < 11; r++) rk[r] = ks[0][r];
    bus.in_data   = cts[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    nacc = 0;
    nout = 0;
    cyc  = 0;
    while (nout < 3 && cyc < 100) begin
      if (bus.in_ready && bus.in_valid && nacc < 3) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      if (bus.out_valid) begin
        check($sformatf("b2b_data_%0d", nout), bus.out_data, pts[nout]);
        nout++;
        if (nout < 3) begin
          for (int r = 0; r < 11; r++) rk[r] = ks[nout][r];
          bus.in_data = cts[nout];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    check("b2b_outputs", 128'(nout), 128'd3);
    check("b2b_accepts", 128'(nacc), 128'd3);
    if (nacc == 3) begin
      check("b2b_gap_01", 128'(acc_t[1] - acc_t[0]), 128'd12);
      check("b2b_gap_12", 128'(acc_t[2] - acc_t[1]), 128'd12);
    end
    bus.out_ready = 1'b0;

    // inv_round undoes a forward round on random states
    for (int i = 0; i < 1000; i++) begin
      x       = rand128();
      k       = rand128();
      ur_last = ($urandom_range(0, 3) == 0);
      ur_key  = k;
      ur_state = ur_last ? shift_rows(sub_bytes(x ^ k))
                         : shift_rows(sub_bytes(mix_columns(x) ^ k));
      #1;
      check(ur_last ? "unit_last" : "unit_mid", ur_out, x);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
